// File: rtl/byte_striping_tx_pkg.sv
// Shared definitions for the byte striping transmitter and its lane-merging receiver.
package byte_striping_tx_pkg;

  localparam int unsigned NUM_LANES = 4;

  localparam int unsigned LANE0_IDX = 0;
  localparam int unsigned LANE1_IDX = 1;
  localparam int unsigned LANE2_IDX = 2;
  localparam int unsigned LANE3_IDX = 3;

  localparam logic [7:0] PAD_DEFAULT = 8'hBC;

  typedef enum logic [NUM_LANES-1:0] {
    LANE0 = 4'b0001,
    LANE1 = 4'b0010,
    LANE2 = 4'b0100,
    LANE3 = 4'b1000
  } lane_e;

  function automatic logic [1:0] lane_index(input logic [NUM_LANES-1:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (onehot[i]) idx = idx | i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/byte_striping_tx_lane_sequencer.sv
// One-hot lane pointer for the striper; flags the cycle in which a group is emitted.
//   state | meaning
//   LANE0 | next accepted byte goes to lane 0 (no partial group held)
//   LANE1 | next accepted byte goes to lane 1
//   LANE2 | next accepted byte goes to lane 2
//   LANE3 | next accepted byte completes the group
module lane_sequencer
  import byte_striping_tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 flush,
  output logic [NUM_LANES-1:0] lane_sel,
  output logic                 group_done
);

  lane_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LANE0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    group_done = 1'b0;
    // A flush with nothing staged and no incoming byte is a no-op.
    if ((valid && state_q == LANE3) || (flush && (valid || state_q != LANE0))) begin
      group_done = 1'b1;
      state_d    = LANE0;
    end else if (valid) begin
      case (state_q)
        LANE0:   state_d = LANE1;
        LANE1:   state_d = LANE2;
        LANE2:   state_d = LANE3;
        default: state_d = LANE0;
      endcase
    end
  end

  assign lane_sel = state_q;

endmodule

// File: rtl/byte_striping_tx.sv
// Transmit byte striper: deals a serial byte stream round-robin over four lanes
// and presents each completed (or flushed, padded) group with a one-cycle strobe.
module byte_striping_tx
  import byte_striping_tx_pkg::*;
#(
  parameter logic [7:0] PAD = PAD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       flush,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out,
  output logic       busy
);

  logic [NUM_LANES-1:0] lane_sel;
  logic                 group_done;
  logic [1:0]           idx;
  logic [7:0]           stage0, stage1, stage2;
  logic [7:0]           cur_byte;
  logic [7:0]           lane0_d, lane1_d, lane2_d, lane3_d;
  logic                 busy_d;

  lane_sequencer u_seq (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .flush      (flush),
    .lane_sel   (lane_sel),
    .group_done (group_done)
  );

  // Lanes below the pointer are staged, the pointer lane takes this cycle's
  // byte if one arrives, and everything above is padding.
  always_comb begin
    idx      = lane_index(lane_sel);
    cur_byte = valid ? data : PAD;
    lane0_d  = (idx > 2'd0) ? stage0 : cur_byte;
    lane1_d  = (idx > 2'd1) ? stage1 : ((idx == 2'd1) ? cur_byte : PAD);
    lane2_d  = (idx > 2'd2) ? stage2 : ((idx == 2'd2) ? cur_byte : PAD);
    lane3_d  = (idx == 2'd3) ? cur_byte : PAD;
    busy_d   = !group_done && (valid || !lane_sel[LANE0_IDX]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage0    <= 8'h00;
      stage1    <= 8'h00;
      stage2    <= 8'h00;
      data_out0 <= 8'h00;
      data_out1 <= 8'h00;
      data_out2 <= 8'h00;
      data_out3 <= 8'h00;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid_out <= group_done;
      busy      <= busy_d;
      if (valid && lane_sel[LANE0_IDX]) stage0 <= data;
      if (valid && lane_sel[LANE1_IDX]) stage1 <= data;
      if (valid && lane_sel[LANE2_IDX]) stage2 <= data;
      if (group_done) begin
        data_out0 <= lane0_d;
        data_out1 <= lane1_d;
        data_out2 <= lane2_d;
        data_out3 <= lane3_d;
      end
    end
  end

endmodule

// File: tb/tb_byte_striping_tx.sv
// Directed plus random checks of byte_striping_tx against a byte-queue reference model.
module tb_byte_striping_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       flush = 1'b0;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out, busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] pend[$];
  logic [7:0] exp_lane[4];
  logic       exp_vo   = 1'b0;
  logic       exp_busy = 1'b0;
  int         n_strobes = 0;

  byte_striping_tx dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .data      (data),
    .flush     (flush),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk1({tag, " valid_out"}, valid_out, exp_vo);
    chk1({tag, " busy"}, busy, exp_busy);
    chk8({tag, " lane0"}, data_out0, exp_lane[0]);
    chk8({tag, " lane1"}, data_out1, exp_lane[1]);
    chk8({tag, " lane2"}, data_out2, exp_lane[2]);
    chk8({tag, " lane3"}, data_out3, exp_lane[3]);
  endtask

  // Reference: bytes queue up; a group leaves when four are held or a flush
  // arrives with anything held, missing lanes filled with the pad byte.
  task automatic model(input logic v, input logic f, input logic [7:0] d);
    if (v) pend.push_back(d);
    if (pend.size() == 4 || (f && pend.size() != 0)) begin
      for (int i = 0; i < 4; i++) exp_lane[i] = (i < pend.size()) ? pend[i] : 8'hBC;
      exp_vo = 1'b1;
      n_strobes++;
      pend.delete();
    end else begin
      exp_vo = 1'b0;
    end
    exp_busy = (pend.size() != 0);
  endtask

  task automatic step(input string tag, input logic v, input logic f, input logic [7:0] d);
    @(negedge clk);
    valid = v;
    flush = f;
    data  = d;
    @(posedge clk);
    #1;
    model(v, f, d);
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'b0, 8'h00);

    for (int i = 1; i <= 8; i++) step("cont", 1'b1, 1'b0, i[7:0]);
    step("cont_after", 1'b0, 1'b0, 8'h00);

    for (int i = 1; i <= 4; i++) begin
      step("gap", 1'b1, 1'b0, {i[3:0], i[3:0]});
      if (i < 4) repeat (3) step("gap_idle", 1'b0, 1'b0, 8'hFF);
    end
    step("gap_after", 1'b0, 1'b0, 8'h00);

    step("part", 1'b1, 1'b0, 8'hA1);
    step("part", 1'b1, 1'b0, 8'hA2);
    step("part_flush", 1'b0, 1'b1, 8'h00);
    step("l0_flush_valid", 1'b1, 1'b1, 8'h5A);
    step("l0_flush_only", 1'b0, 1'b1, 8'h00);
    step("idle2", 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 3; i++) step("b2b_flush", 1'b1, 1'b1, 8'hC0 + i[7:0]);
    step("l1_fv", 1'b1, 1'b0, 8'hD1);
    step("l1_fv", 1'b1, 1'b1, 8'hD2);
    for (int i = 0; i < 3; i++) step("l3_fv", 1'b1, 1'b0, 8'hE0 + i[7:0]);
    step("l3_fv", 1'b1, 1'b1, 8'hE3);

    step("rst_grp", 1'b1, 1'b0, 8'h10);
    step("rst_grp", 1'b1, 1'b0, 8'h20);
    step("rst_grp", 1'b1, 1'b0, 8'h30);
    valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    pend.delete();
    for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;
    exp_vo   = 1'b0;
    exp_busy = 1'b0;
    check_all("async_rst");
    #1 reset = 1'b1;
    step("post_rst", 1'b0, 1'b0, 8'h00);
    step("post_rst", 1'b1, 1'b0, 8'h40);
    step("post_rst", 1'b1, 1'b0, 8'h50);
    step("post_rst", 1'b1, 1'b0, 8'h60);
    step("post_rst", 1'b1, 1'b0, 8'h70);
    chk8("post_rst grp lane0", data_out0, 8'h40);
    chk8("post_rst grp lane3", data_out3, 8'h70);

    for (int i = 0; i < 400; i++) begin
      logic v, f;
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 19) < 3);
      step("rand", v, f, 8'($urandom));
    end
    step("final", 1'b0, 1'b1, 8'h00);
    step("final", 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
